// File: rtl/fwd_src_tracker.sv
// Producer-side forwarding scoreboard for a five-stage pipeline.
// Tracks destination GPR and result latency of the instructions in E, M and W,
// and resolves one D-stage operand lookup per cycle into a forward source or a stall.
module fwd_src_tracker #(
  parameter int unsigned AW    = 5,
  parameter int unsigned TW    = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_we,
  input  logic [AW-1:0]    d_wa,
  input  logic [TW-1:0]    d_tnew,
  input  logic [AW-1:0]    q_reg,
  input  logic [TW-1:0]    q_tuse,
  output logic [1:0]       q_src,
  output logic             q_stall,
  output logic [AW-1:0]    e_wa,
  output logic [AW-1:0]    m_wa,
  output logic [AW-1:0]    w_wa,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SrcRf = 2'd0;
  localparam logic [1:0] SrcE  = 2'd1;
  localparam logic [1:0] SrcM  = 2'd2;
  localparam logic [1:0] SrcW  = 2'd3;

  // W never needs a tnew field: its result always exists, so its tnew is implicitly 0.
  logic             e_vld_q, e_vld_d;
  logic [AW-1:0]    e_wa_q, e_wa_d;
  logic [TW-1:0]    e_tnew_q, e_tnew_d;
  logic             m_vld_q, m_vld_d;
  logic [AW-1:0]    m_wa_q, m_wa_d;
  logic [TW-1:0]    m_tnew_q, m_tnew_d;
  logic             w_vld_q, w_vld_d;
  logic [AW-1:0]    w_wa_q, w_wa_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operand lookup: youngest matching slot decides, older matches are shadowed.
  always_comb begin
    q_src   = SrcRf;
    q_stall = 1'b0;
    if (q_reg != '0) begin
      if (e_vld_q && (e_wa_q == q_reg)) begin
        if (e_tnew_q == '0)         q_src   = SrcE;
        else if (e_tnew_q > q_tuse) q_stall = 1'b1;
      end else if (m_vld_q && (m_wa_q == q_reg)) begin
        if (m_tnew_q == '0)         q_src   = SrcM;
        else if (m_tnew_q > q_tuse) q_stall = 1'b1;
      end else if (w_vld_q && (w_wa_q == q_reg)) begin
        q_src = SrcW;
      end
    end
  end

  // Next-state: advance the pipeline slots, inject a bubble into E while stalling.
  always_comb begin
    w_vld_d  = m_vld_q;
    w_wa_d   = m_wa_q;
    m_vld_d  = e_vld_q;
    m_wa_d   = e_wa_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TW'(1);
    if (q_stall) begin
      e_vld_d  = 1'b0;
      e_wa_d   = '0;
      e_tnew_d = '0;
    end else begin
      // Writes to $0 are architecturally discarded, so they are never tracked.
      e_vld_d  = d_we && (d_wa != '0);
      e_wa_d   = d_wa;
      e_tnew_d = d_tnew;
    end
    cnt_d = cnt_q;
    if (q_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_vld_q  <= 1'b0;
      e_wa_q   <= '0;
      e_tnew_q <= '0;
      m_vld_q  <= 1'b0;
      m_wa_q   <= '0;
      m_tnew_q <= '0;
      w_vld_q  <= 1'b0;
      w_wa_q   <= '0;
      cnt_q    <= '0;
    end else begin
      e_vld_q  <= e_vld_d;
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      m_vld_q  <= m_vld_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      w_vld_q  <= w_vld_d;
      w_wa_q   <= w_wa_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot address outputs read as 0 for empty slots.
  always_comb begin
    e_wa      = e_vld_q ? e_wa_q : '0;
    m_wa      = m_vld_q ? m_wa_q : '0;
    w_wa      = w_vld_q ? w_wa_q : '0;
    stall_cnt = cnt_q;
  end

endmodule

// File: tb/tb_fwd_src_tracker.sv
// Directed bench for fwd_src_tracker; a second instance with a 4-bit counter
// shares all inputs so counter saturation is reached in a short run.
module tb_fwd_src_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_we;
  logic [4:0]  d_wa;
  logic [1:0]  d_tnew;
  logic [4:0]  q_reg;
  logic [1:0]  q_tuse;
  logic [1:0]  q_src;
  logic        q_stall;
  logic [4:0]  e_wa, m_wa, w_wa;
  logic [15:0] stall_cnt;

  logic [1:0]  s_q_src;
  logic        s_q_stall;
  logic [4:0]  s_e_wa, s_m_wa, s_w_wa;
  logic [3:0]  s_stall_cnt;

  int tests = 0;
  int fails = 0;

  fwd_src_tracker u_dut (
    .clk       (clk),
    .reset     (reset),
    .d_we      (d_we),
    .d_wa      (d_wa),
    .d_tnew    (d_tnew),
    .q_reg     (q_reg),
    .q_tuse    (q_tuse),
    .q_src     (q_src),
    .q_stall   (q_stall),
    .e_wa      (e_wa),
    .m_wa      (m_wa),
    .w_wa      (w_wa),
    .stall_cnt (stall_cnt)
  );

  fwd_src_tracker #(.CNT_W(4)) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .d_we      (d_we),
    .d_wa      (d_wa),
    .d_tnew    (d_tnew),
    .q_reg     (q_reg),
    .q_tuse    (q_tuse),
    .q_src     (s_q_src),
    .q_stall   (s_q_stall),
    .e_wa      (s_e_wa),
    .m_wa      (s_m_wa),
    .w_wa      (s_w_wa),
    .stall_cnt (s_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (tests=%0d failed=%0d)", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [1:0] tn,
                       input logic [4:0] qr, input logic [1:0] tu);
    d_we = we; d_wa = wa; d_tnew = tn; q_reg = qr; q_tuse = tu;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (q_src !== 2'd0 || q_stall !== 1'b0) begin
      fails++; $display("FAIL reset_query: src=%0d stall=%0d, want src=0 stall=0", q_src, q_stall);
    end
    tests++;
    if (e_wa !== 5'd0 || m_wa !== 5'd0 || w_wa !== 5'd0 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: e=%0d m=%0d w=%0d cnt=%0d, want all 0", e_wa, m_wa, w_wa,
               stall_cnt);
    end
  endtask

  // Load $8 (tnew=2), consumer tuse=1: one stall, wait in M, then forward from W.
  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd8, 2'd2, 5'd0, 2'd0);
    tick();
    // Present a different writer while stalled; it must be ignored.
    drive(1'b1, 5'd20, 2'd1, 5'd8, 2'd1);
    tests++;
    if (q_stall !== 1'b1 || q_src !== 2'd0 || e_wa !== 5'd8) begin
      fails++;
      $display("FAIL load_stall: stall=%0d src=%0d e_wa=%0d, want 1 0 8", q_stall, q_src, e_wa);
    end
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd8, 2'd1);
    tests++;
    if (q_stall !== 1'b0 || q_src !== 2'd0 || m_wa !== 5'd8 || e_wa !== 5'd0) begin
      fails++;
      $display("FAIL load_in_m: stall=%0d src=%0d m_wa=%0d e_wa=%0d, want 0 0 8 0", q_stall,
               q_src, m_wa, e_wa);
    end
    tick();
    tests++;
    if (q_stall !== 1'b0 || q_src !== 2'd3 || w_wa !== 5'd8) begin
      fails++;
      $display("FAIL load_fwd_w: stall=%0d src=%0d w_wa=%0d, want 0 3 8", q_stall, q_src, w_wa);
    end
    tick();
    tests++;
    if (q_src !== 2'd0 || q_stall !== 1'b0 || stall_cnt !== 16'd1) begin
      fails++;
      $display("FAIL load_drained: src=%0d stall=%0d cnt=%0d, want 0 0 1", q_src, q_stall,
               stall_cnt);
    end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drive(1'b1, 5'd5, 2'd1, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd5, 2'd0);
    tests++;
    if (q_stall !== 1'b1 || q_src !== 2'd0) begin
      fails++; $display("FAIL alu_tuse0_stall: stall=%0d src=%0d, want 1 0", q_stall, q_src);
    end
    tick();
    tests++;
    if (q_stall !== 1'b0 || q_src !== 2'd2) begin
      fails++; $display("FAIL alu_fwd_m: stall=%0d src=%0d, want 0 2", q_stall, q_src);
    end
    drive(1'b1, 5'd5, 2'd1, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd5, 2'd1);
    tests++;
    if (q_stall !== 1'b0 || q_src !== 2'd0) begin
      fails++; $display("FAIL alu_tuse1_nostall: stall=%0d src=%0d, want 0 0", q_stall, q_src);
    end
    tick();
    tests++;
    if (q_stall !== 1'b0 || q_src !== 2'd2) begin
      fails++; $display("FAIL alu_tuse1_fwd_m: stall=%0d src=%0d, want 0 2", q_stall, q_src);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1'b1, 5'd9, 2'd1, 5'd0, 2'd0);
    tick();
    drive(1'b1, 5'd9, 2'd0, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd9, 2'd0);
    tests++;
    if (q_src !== 2'd1 || q_stall !== 1'b0 || e_wa !== 5'd9 || m_wa !== 5'd9) begin
      fails++;
      $display("FAIL e_over_m: src=%0d stall=%0d e=%0d m=%0d, want 1 0 9 9", q_src, q_stall,
               e_wa, m_wa);
    end
    // Younger unready producer shadows a ready older one.
    do_reset();
    drive(1'b1, 5'd9, 2'd0, 5'd0, 2'd0);
    tick();
    drive(1'b1, 5'd9, 2'd2, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd9, 2'd0);
    tests++;
    if (q_stall !== 1'b1 || q_src !== 2'd0) begin
      fails++; $display("FAIL shadow_stall: stall=%0d src=%0d, want 1 0", q_stall, q_src);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1'b1, 5'd0, 2'd2, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0);
    tests++;
    if (q_src !== 2'd0 || q_stall !== 1'b0 || e_wa !== 5'd0) begin
      fails++;
      $display("FAIL zero_reg: src=%0d stall=%0d e_wa=%0d, want 0 0 0", q_src, q_stall, e_wa);
    end
    // A non-writing instruction is a bubble even with a nonzero address.
    drive(1'b0, 5'd6, 2'd2, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd6, 2'd0);
    tests++;
    if (q_stall !== 1'b0 || e_wa !== 5'd0) begin
      fails++; $display("FAIL no_we_bubble: stall=%0d e_wa=%0d, want 0 0", q_stall, e_wa);
    end
  endtask

  // Repeating tnew=3 producer against a tuse=0 consumer stalls 2 of every 3 cycles.
  task automatic test_stall_cnt();
    do_reset();
    drive(1'b1, 5'd7, 2'd3, 5'd7, 2'd0);
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (stall_cnt !== 16'd4 || s_stall_cnt !== 4'd4) begin
      fails++; $display("FAIL cnt_6: cnt=%0d sat=%0d, want 4 4", stall_cnt, s_stall_cnt);
    end
    for (int i = 0; i < 24; i++) tick();
    tests++;
    if (stall_cnt !== 16'd20 || s_stall_cnt !== 4'hF) begin
      fails++; $display("FAIL cnt_30: cnt=%0d sat=%0d, want 20 15", stall_cnt, s_stall_cnt);
    end
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (stall_cnt !== 16'd22 || s_stall_cnt !== 4'hF) begin
      fails++; $display("FAIL cnt_hold: cnt=%0d sat=%0d, want 22 15", stall_cnt, s_stall_cnt);
    end
    do_reset();
    tests++;
    if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0 || e_wa !== 5'd0 || m_wa !== 5'd0 ||
        w_wa !== 5'd0) begin
      fails++;
      $display("FAIL cnt_reset: cnt=%0d sat=%0d e=%0d m=%0d w=%0d, want all 0", stall_cnt,
               s_stall_cnt, e_wa, m_wa, w_wa);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 5'd12, 2'd2, 5'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'd0, 5'd12, 2'd0);
    tests++;
    if (q_stall !== 1'b1 || m_wa !== 5'd12) begin
      fails++; $display("FAIL mid_pre: stall=%0d m_wa=%0d, want 1 12", q_stall, m_wa);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (q_src !== 2'd0 || q_stall !== 1'b0 || m_wa !== 5'd0 || w_wa !== 5'd0 ||
        stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL mid_reset: src=%0d stall=%0d m=%0d w=%0d cnt=%0d, want all 0", q_src,
               q_stall, m_wa, w_wa, stall_cnt);
    end
    tick();
    tests++;
    if (q_src !== 2'd0 || q_stall !== 1'b0) begin
      fails++; $display("FAIL mid_no_stale: src=%0d stall=%0d, want 0 0", q_src, q_stall);
    end
  endtask

  initial begin
    reset = 1'b1;
    d_we = 1'b0; d_wa = '0; d_tnew = '0; q_reg = '0; q_tuse = '0;
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_priority();
    test_zero_reg();
    test_stall_cnt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
